// File: rtl/sram_rr_ctrl_pkg.sv
// Shared types and helpers for the round-robin SRAM access controller.
package sram_rr_pkg;

  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, RESP} state_t;

  // Upper bound on requester count supported by rr_pick
  localparam int MAX_REQ = 32;

  typedef struct packed {
    logic       found;
    logic [4:0] idx;
  } pick_t;

  function automatic int cnt_w(input int lat);
    return $clog2(lat + 1);
  endfunction

  // First set bit of valid, scanning from last+1 and wrapping modulo n
  function automatic pick_t rr_pick(input logic [MAX_REQ-1:0] valid,
                                    input logic [4:0]         last,
                                    input int                 n);
    pick_t      p;
    int         j;
    logic [4:0] jj;
    p = '0;
    for (int k = MAX_REQ; k >= 1; k--) begin
      if (k <= n) begin
        j  = (int'(last) + k) % n;
        jj = 5'(j);
        if (valid[jj]) begin
          p.found = 1'b1;
          p.idx   = jj;
        end
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/sram_rr_ctrl_pick.sv
// Combinational round-robin selector: grants the first valid requester after last.
module sram_rr_pick
  import sram_rr_pkg::*;
#(
  parameter int NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0]         valid,
  input  logic [$clog2(NUM_REQ)-1:0] last,
  output logic [$clog2(NUM_REQ)-1:0] grant,
  output logic                       any
);
  localparam int IDX_W = $clog2(NUM_REQ);

  pick_t              p;
  logic [MAX_REQ-1:0] v;

  always_comb begin
    v                = '0;
    v[NUM_REQ-1:0]   = valid;
    p                = rr_pick(v, 5'(last), NUM_REQ);
    grant            = IDX_W'(p.idx);
    any              = p.found;
  end

endmodule

// File: rtl/sram_rr_ctrl.sv
// Round-robin controller sharing one single-port SRAM macro between NUM_REQ
// requesters; one access in flight, operands held SRAM_LATENCY cycles.
module sram_rr_ctrl
  import sram_rr_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 8,
  parameter int WMASK_WIDTH  = 4,
  parameter int NUM_REQ      = 2,
  parameter int SRAM_LATENCY = 2
) (
  input  logic                            clock,
  input  logic                            reset_n,
  input  logic [NUM_REQ-1:0]              req_valid,
  output logic [NUM_REQ-1:0]              req_ready,
  input  logic [NUM_REQ-1:0]              req_we,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]   req_addr,
  input  logic [NUM_REQ*WMASK_WIDTH-1:0]  req_wmask,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_wdata,
  output logic [NUM_REQ-1:0]              resp_valid,
  input  logic [NUM_REQ-1:0]              resp_ready,
  output logic [DATA_WIDTH-1:0]           resp_rdata,
  output logic                            sram_we,
  output logic [WMASK_WIDTH-1:0]          sram_wmask,
  output logic [ADDR_WIDTH-1:0]           sram_addr,
  output logic [DATA_WIDTH-1:0]           sram_din,
  input  logic [DATA_WIDTH-1:0]           sram_dout,
  output logic                            busy
);
  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = cnt_w(SRAM_LATENCY);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SRAM_LATENCY - 1);

  typedef struct packed {
    logic                   we;
    logic [ADDR_WIDTH-1:0]  addr;
    logic [WMASK_WIDTH-1:0] wmask;
    logic [DATA_WIDTH-1:0]  wdata;
  } op_t;

  state_t            state, state_nx;
  logic [CNT_W-1:0]  cnt;
  logic [IDX_W-1:0]  g, last, pick;
  logic              any;
  op_t               op, op_in;
  logic [DATA_WIDTH-1:0] rdata;

  sram_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .valid (req_valid),
    .last  (last),
    .grant (pick),
    .any   (any)
  );

  always_comb begin
    op_in.we    = req_we[pick];
    op_in.addr  = req_addr[pick*ADDR_WIDTH +: ADDR_WIDTH];
    op_in.wmask = req_wmask[pick*WMASK_WIDTH +: WMASK_WIDTH];
    op_in.wdata = req_wdata[pick*DATA_WIDTH +: DATA_WIDTH];
  end

  // Grant is masked while reset is asserted so no handshake can be seen then
  always_comb begin
    state_nx   = state;
    req_ready  = '0;
    resp_valid = '0;
    sram_we    = 1'b0;
    case (state)
      IDLE: begin
        if (any && reset_n) begin
          req_ready[pick] = 1'b1;
          state_nx        = ISSUE;
        end
      end
      ISSUE: begin
        sram_we = op.we;
        if (cnt == CNT_LAST) state_nx = op.we ? RESP : CAPTURE;
      end
      CAPTURE: state_nx = RESP;
      RESP: begin
        resp_valid[g] = 1'b1;
        if (resp_ready[g]) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state <= IDLE;
      cnt   <= '0;
      g     <= '0;
      last  <= IDX_W'(NUM_REQ - 1);
      op    <= '0;
      rdata <= '0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: begin
          if (any) begin
            g     <= pick;
            op    <= op_in;
            cnt   <= '0;
            rdata <= '0;
          end
        end
        ISSUE:   cnt   <= cnt + 1'b1;
        CAPTURE: rdata <= sram_dout;
        RESP:    if (resp_ready[g]) last <= g;
        default: ;
      endcase
    end
  end

  // Operands stay on the macro pins after the access so the address is held
  assign sram_addr  = op.addr;
  assign sram_din   = op.wdata;
  assign sram_wmask = op.wmask;
  assign resp_rdata = rdata;
  assign busy       = (state != IDLE);

endmodule

// File: tb/tb_sram_rr_ctrl.sv
// Scoreboard bench for sram_rr_ctrl: directed scenarios plus randomized traffic
// checked against a reference memory and a round-robin grant model.
module tb_sram_rr_ctrl;
  localparam int DW = 32, AW = 8, MW = 4, N = 2, L = 2, BW = DW / MW;

  logic              clock = 1'b0, reset_n = 1'b0;
  logic [N-1:0]      req_valid = '0, req_we = '0, resp_ready = '1;
  logic [N-1:0]      req_ready, resp_valid;
  logic [N*AW-1:0]   req_addr = '0;
  logic [N*MW-1:0]   req_wmask = '0;
  logic [N*DW-1:0]   req_wdata = '0;
  logic [DW-1:0]     resp_rdata, sram_din, sram_dout;
  logic              sram_we, busy;
  logic [MW-1:0]     sram_wmask;
  logic [AW-1:0]     sram_addr;

  always #5 clock = ~clock;

  sram_rr_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .WMASK_WIDTH(MW),
                 .NUM_REQ(N), .SRAM_LATENCY(L)) dut (
    .clock(clock), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wmask(req_wmask), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .sram_we(sram_we), .sram_wmask(sram_wmask), .sram_addr(sram_addr),
    .sram_din(sram_din), .sram_dout(sram_dout), .busy(busy)
  );

  function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
    return (32'h9E37_79B9 * (32'(a) + 32'd1)) ^ 32'h0F0F_5A5A;
  endfunction

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] wd,
                                          input logic [MW-1:0] m);
    logic [DW-1:0] r;
    r = old;
    for (int b = 0; b < MW; b++) if (m[b]) r[b*BW +: BW] = wd[b*BW +: BW];
    return r;
  endfunction

  // Macro model: write on registered we, read-first registered dout
  logic [DW-1:0] mem [1<<AW];
  logic          loaded = 1'b0;
  always @(posedge clock) begin
    if (!loaded) begin
      for (int a = 0; a < (1 << AW); a++) mem[a] <= init_val(AW'(a));
      loaded <= 1'b1;
    end else begin
      if (sram_we) mem[sram_addr] <= merge(mem[sram_addr], sram_din, sram_wmask);
      sram_dout <= mem[sram_addr];
    end
  end

  typedef struct {
    int            idx;
    bit            we;
    logic [AW-1:0] addr;
    logic [MW-1:0] wmask;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
    int            acc_cyc;
  } exp_t;

  exp_t          q[$];
  exp_t          cur, e;
  logic [DW-1:0] ref_mem [int];
  int            tests = 0, fails = 0, cyc = 0, to_cnt = 0, to_seen = 0;
  int            last_m = N - 1, we_cnt = 0;
  bit            seen = 1'b0, rst_sampled = 1'b0;
  logic [N-1:0]  hs_next = '0, exp_vec, acc;

  function automatic logic [DW-1:0] ref_rd(input logic [AW-1:0] a);
    return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : init_val(a);
  endfunction

  function automatic int rr_ref(input logic [N-1:0] v, input int last);
    for (int k = 1; k <= N; k++) if (v[(last + k) % N]) return (last + k) % N;
    return 0;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  initial forever begin
    @(posedge clock);
    cyc++;
    rst_sampled = !reset_n;
  end

  // Monitor: compares at the falling edge, pushes expectations at accepts
  initial forever begin
    @(negedge clock);
    if (to_cnt != to_seen) begin
      check("wait_timeout", 64'(to_cnt), 64'(to_seen));
      to_seen = to_cnt;
    end
    hs_next = '0;
    if (!reset_n) begin
      q.delete();
      we_cnt = 0;
      seen   = 1'b0;
      last_m = N - 1;
      if (rst_sampled) begin
        check("rst_sram_we",    64'(sram_we),    64'd0);
        check("rst_sram_addr",  64'(sram_addr),  64'd0);
        check("rst_sram_din",   64'(sram_din),   64'd0);
        check("rst_sram_wmask", 64'(sram_wmask), 64'd0);
        check("rst_resp_valid", 64'(resp_valid), 64'd0);
        check("rst_resp_rdata", 64'(resp_rdata), 64'd0);
        check("rst_req_ready",  64'(req_ready),  64'd0);
        check("rst_busy",       64'(busy),       64'd0);
      end
    end else begin
      exp_vec = '0;
      if (q.size() == 0 && req_valid != '0) exp_vec[rr_ref(req_valid, last_m)] = 1'b1;
      check("req_ready", 64'(req_ready), 64'(exp_vec));
      check("busy", 64'(busy), 64'(q.size() != 0));
      if (q.size() != 0) begin
        cur = q[0];
        check("sram_addr", 64'(sram_addr), 64'(cur.addr));
        if (sram_we) begin
          we_cnt++;
          check("sram_din",   64'(sram_din),   64'(cur.wdata));
          check("sram_wmask", 64'(sram_wmask), 64'(cur.wmask));
        end
        if (resp_valid != '0) begin
          if (!seen) begin
            seen = 1'b1;
            check("resp_latency", 64'(cyc - cur.acc_cyc), 64'(cur.we ? L + 1 : L + 2));
          end
          exp_vec = '0;
          exp_vec[cur.idx] = 1'b1;
          check("resp_valid", 64'(resp_valid), 64'(exp_vec));
          check("resp_rdata", 64'(resp_rdata), 64'(cur.rdata));
          if (resp_ready[cur.idx]) begin
            check("we_cycles", 64'(we_cnt), 64'(cur.we ? L : 0));
            last_m = cur.idx;
            void'(q.pop_front());
            we_cnt = 0;
            seen   = 1'b0;
          end
        end
      end else begin
        check("idle_resp_valid", 64'(resp_valid), 64'd0);
        check("idle_sram_we",    64'(sram_we),    64'd0);
      end
      acc = req_valid & req_ready;
      for (int i = 0; i < N; i++) begin
        if (acc[i]) begin
          e.idx     = i;
          e.we      = req_we[i];
          e.addr    = req_addr[i*AW +: AW];
          e.wmask   = req_wmask[i*MW +: MW];
          e.wdata   = req_wdata[i*DW +: DW];
          e.acc_cyc = cyc;
          if (e.we) begin
            ref_mem[int'(e.addr)] = merge(ref_rd(e.addr), e.wdata, e.wmask);
            e.rdata = '0;
          end else begin
            e.rdata = ref_rd(e.addr);
          end
          q.push_back(e);
        end
      end
      hs_next = acc;
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_req(input int i, input bit we, input int a, input logic [MW-1:0] m,
                         input logic [DW-1:0] d);
    req_we[i]               = we;
    req_addr[i*AW +: AW]    = AW'(a);
    req_wmask[i*MW +: MW]   = m;
    req_wdata[i*DW +: DW]   = d;
    req_valid[i]            = 1'b1;
  endtask

  task automatic wait_hs(input int i);
    int n;
    n = 0;
    do begin tick(); n++; end while (!hs_next[i] && n < 100);
    if (!hs_next[i]) to_cnt++;
    req_valid[i] = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((q.size() != 0 || busy) && n < 200) begin tick(); n++; end
    if (n >= 200) to_cnt++;
  endtask

  initial begin
    bit was;
    repeat (3) tick();
    reset_n = 1'b1;

    // single write, read-back, zero-mask write, partial mask at the top address
    set_req(0, 1'b1, 5, '1, 32'd13);              wait_hs(0); wait_idle();
    set_req(1, 1'b0, 5, '0, '0);                  wait_hs(1); wait_idle();
    set_req(1, 1'b1, 255, 4'b0000, 32'hDEAD_BEEF); wait_hs(1); wait_idle();
    set_req(0, 1'b1, 255, 4'b0101, 32'h1122_3344); wait_hs(0); wait_idle();
    set_req(1, 1'b0, 255, '0, '0);                wait_hs(1); wait_idle();

    // contention: both valid from reset, new read address after each grant
    reset_n = 1'b0;
    set_req(0, 1'b0, 10, '0, '0);
    set_req(1, 1'b0, 20, '0, '0);
    repeat (2) tick();
    reset_n = 1'b1;
    repeat (40) begin
      tick();
      for (int i = 0; i < N; i++)
        if (hs_next[i]) req_addr[i*AW +: AW] = AW'($urandom_range(0, 31));
    end
    req_valid = '0;
    wait_idle();

    // response backpressure while requester 1 waits
    resp_ready[0] = 1'b0;
    set_req(0, 1'b1, 3, '1, 32'hA5A5_0003); wait_hs(0);
    set_req(1, 1'b0, 3, '0, '0);
    repeat (14) tick();
    resp_ready[0] = 1'b1;
    wait_hs(1);
    wait_idle();

    // reset during a write's ISSUE phase, then read back
    set_req(0, 1'b1, 7, '1, 32'h0000_0777); wait_hs(0);
    reset_n = 1'b0;
    tick(); tick();
    reset_n = 1'b1;
    set_req(0, 1'b0, 7, '0, '0);
    set_req(1, 1'b0, 8, '0, '0);
    wait_hs(0); wait_hs(1); wait_idle();

    // randomized traffic with withdrawals and response backpressure
    repeat (3000) begin
      tick();
      for (int i = 0; i < N; i++) begin
        was = req_valid[i];
        if (hs_next[i] || (was && $urandom_range(0, 15) == 0)) req_valid[i] = 1'b0;
        else if (!was && $urandom_range(0, 2) == 0)
          set_req(i, 1'($urandom_range(0, 1)), int'($urandom_range(0, 15)), MW'($urandom), $urandom);
      end
      resp_ready = N'($urandom) | N'($urandom);
    end
    req_valid  = '0;
    resp_ready = '1;
    wait_idle();
    repeat (3) tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
